// File: rtl/led_pattern_gen.sv
// Parametrised LED sequencer: eight step patterns (rotate, flash, bounce, bar,
// user rotate, PWM breathe) advanced by a programmable single-clock step enable.
module led_pattern_gen #(
  parameter int LED_W   = 8,
  parameter int SPEED_W = 32,
  parameter int PWM_W   = 8
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic [2:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               cnt_clear,
  input  logic               pattern_load,
  input  logic [LED_W-1:0]   pattern_in,
  output logic [LED_W-1:0]   led,
  output logic               step
);

  localparam int POS_W = (LED_W > 2) ? $clog2(LED_W) : 1;
  localparam int BAR_W = $clog2(LED_W + 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(LED_W - 1);
  localparam logic [BAR_W-1:0] BAR_MAX  = BAR_W'(LED_W);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  logic [SPEED_W-1:0] prescaler_reg, prescaler_next;
  logic [2:0]         mode_reg;
  logic [POS_W-1:0]   pos_reg, pos_next;
  logic               dir_reg, dir_next;
  logic [BAR_W-1:0]   bar_reg, bar_next;
  logic [PWM_W-1:0]   duty_reg, duty_next;
  logic               duty_dir_reg, duty_dir_next;
  logic [PWM_W-1:0]   pwm_cnt_reg;
  logic               flash_reg, flash_next;
  logic [LED_W-1:0]   user_pat_reg;
  logic [LED_W-1:0]   led_reg, led_next;
  logic               step_reg;

  logic               mode_change, at_match, tick;
  logic [LED_W-1:0]   onehot_l, onehot_r, bar_mask, user_rot;
  logic               pwm_on;

  assign mode_change = (mode != mode_reg);
  assign at_match    = (prescaler_reg == speed);
  assign tick        = !mode_change && !cnt_clear && at_match;

  // A lowered speed simply lets the counter wrap through all-ones.
  assign prescaler_next = (mode_change || cnt_clear || at_match) ? '0
                                                                 : prescaler_reg + SPEED_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_bit
      assign onehot_l[gi] = (pos_reg == POS_W'(gi));
      assign onehot_r[gi] = (pos_reg == POS_W'(LED_W - 1 - gi));
      assign bar_mask[gi] = (BAR_W'(gi) < bar_reg);
    end
  endgenerate

  assign user_rot = (user_pat_reg << pos_reg) | (user_pat_reg >> (LED_W - int'(pos_reg)));
  assign pwm_on   = (pwm_cnt_reg < duty_reg);

  always_comb begin
    pos_next      = pos_reg;
    dir_next      = dir_reg;
    bar_next      = bar_reg;
    duty_next     = duty_reg;
    duty_dir_next = duty_dir_reg;
    flash_next    = flash_reg;
    if (mode_change) begin
      pos_next      = '0;
      dir_next      = 1'b0;
      bar_next      = '0;
      duty_next     = '0;
      duty_dir_next = 1'b0;
      flash_next    = 1'b0;
    end else if (tick) begin
      case (mode_reg)
        3'd1, 3'd2, 3'd6: pos_next = (pos_reg == POS_MAX) ? '0 : pos_reg + POS_W'(1);
        3'd3: flash_next = ~flash_reg;
        3'd4: begin
          // Turn around at either end so the end LED is not shown twice.
          if (!dir_reg) begin
            if (pos_reg == POS_MAX) begin
              dir_next = 1'b1;
              pos_next = pos_reg - POS_W'(1);
            end else begin
              pos_next = pos_reg + POS_W'(1);
            end
          end else begin
            if (pos_reg == '0) begin
              dir_next = 1'b0;
              pos_next = POS_W'(1);
            end else begin
              pos_next = pos_reg - POS_W'(1);
            end
          end
        end
        3'd5: bar_next = (bar_reg == BAR_MAX) ? '0 : bar_reg + BAR_W'(1);
        3'd7: begin
          // The endpoint tick only flips direction, so the extreme duty lasts two ticks.
          if (!duty_dir_reg) begin
            if (duty_reg == DUTY_MAX) duty_dir_next = 1'b1;
            else                      duty_next     = duty_reg + PWM_W'(1);
          end else begin
            if (duty_reg == '0) duty_dir_next = 1'b0;
            else                duty_next     = duty_reg - PWM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_next = '0;
    case (mode_reg)
      3'd1, 3'd4: led_next = onehot_l;
      3'd2:       led_next = onehot_r;
      3'd3:       led_next = {LED_W{flash_reg}};
      3'd5:       led_next = bar_mask;
      3'd6:       led_next = user_rot;
      3'd7:       led_next = {LED_W{pwm_on}};
      default:    led_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      prescaler_reg <= '0;
      mode_reg      <= mode;
      pos_reg       <= '0;
      dir_reg       <= 1'b0;
      bar_reg       <= '0;
      duty_reg      <= '0;
      duty_dir_reg  <= 1'b0;
      pwm_cnt_reg   <= '0;
      flash_reg     <= 1'b0;
      user_pat_reg  <= LED_W'(1);
      led_reg       <= '0;
      step_reg      <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      mode_reg      <= mode;
      pos_reg       <= pos_next;
      dir_reg       <= dir_next;
      bar_reg       <= bar_next;
      duty_reg      <= duty_next;
      duty_dir_reg  <= duty_dir_next;
      pwm_cnt_reg   <= pwm_cnt_reg + PWM_W'(1);
      flash_reg     <= flash_next;
      if (pattern_load) user_pat_reg <= pattern_in;
      led_reg       <= led_next;
      step_reg      <= tick;
    end
  end

  assign led  = led_reg;
  assign step = step_reg;

endmodule
